// File: rtl/rx.sv
// UART receiver: 1 start bit, 8 data bits LSB first, odd parity, 1 stop bit.
// The received byte and its parity/framing status are held under a
// Received/ReceiveAck handshake until the consumer acknowledges.
module rx #(
  parameter int BIT_CYCLES  = 5209,
  parameter int HALF_CYCLES = 2604
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Sin,
  input  logic       ReceiveAck,
  output logic       Received,
  output logic [7:0] Dout,
  output logic       parityErr,
  output logic       stopErr,
  output logic [2:0] dbg_state
);

  // Handshake: Received is high exactly while a completed byte is held in
  // ACK. Dout/parityErr/stopErr are stable whenever Received is high. The
  // consumer raises ReceiveAck while Received is high; the byte is taken on
  // that clock edge and Received drops on the following cycle. ReceiveAck
  // has no effect outside ACK, so it may be held high permanently, in which
  // case Received is a one-cycle pulse per frame.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BITS  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4,
    S_ACK   = 3'd5
  } state_t;

  localparam logic [12:0] HALF_LAST = 13'(HALF_CYCLES - 1);
  localparam logic [12:0] BIT_LAST  = 13'(BIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        sin_meta_q, sin_meta_d;
  logic        sin_s_q, sin_s_d;
  logic [12:0] timer_q, timer_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [7:0]  dout_q, dout_d;
  logic        perr_q, perr_d;
  logic        serr_q, serr_d;
  logic        received_q, received_d;

  logic        half_done;
  logic        timer_done;
  logic        bit_done;

  assign half_done  = (timer_q == HALF_LAST);
  assign timer_done = (timer_q == BIT_LAST);
  assign bit_done   = (cnt_q == 3'd7);

  assign Received  = received_q;
  assign Dout      = dout_q;
  assign parityErr = perr_q;
  assign stopErr   = serr_q;
  assign dbg_state = state_q;

  // Next-state logic: synchronizer, bit timer, bit counter, shifter and FSM.
  always_comb begin
    sin_meta_d = Sin;
    sin_s_d    = sin_meta_q;
    state_d    = state_q;
    timer_d    = timer_done ? 13'd0 : timer_q + 13'd1;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    dout_d     = dout_q;
    perr_d     = perr_q;
    serr_d     = serr_q;

    case (state_q)
      S_IDLE: begin
        timer_d = 13'd0;
        if (!sin_s_q) state_d = S_START;
      end
      S_START: begin
        // Mid-point re-check rejects glitches shorter than half a bit.
        if (half_done) state_d = sin_s_q ? S_IDLE : S_BITS;
      end
      S_BITS: begin
        if (timer_done) begin
          shift_d = {sin_s_q, shift_q[7:1]};
          if (bit_done) state_d = S_PAR;
          else          cnt_d   = cnt_q + 3'd1;
        end
      end
      S_PAR: begin
        if (timer_done) begin
          par_d   = sin_s_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (timer_done) begin
          dout_d  = shift_q;
          perr_d  = ~(^{shift_q, par_q});
          serr_d  = ~sin_s_q;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (ReceiveAck) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Every state change restarts the bit timer so each phase is measured
    // from its own entry.
    if (state_d != state_q) timer_d = 13'd0;
    if ((state_d == S_BITS) && (state_q != S_BITS)) cnt_d = 3'd0;

    received_d = (state_d == S_ACK);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      sin_meta_q <= 1'b1;
      sin_s_q    <= 1'b1;
      timer_q    <= 13'd0;
      cnt_q      <= 3'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      dout_q     <= 8'h00;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
      received_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sin_meta_q <= sin_meta_d;
      sin_s_q    <= sin_s_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      dout_q     <= dout_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
      received_q <= received_d;
    end
  end

endmodule

// File: tb/tb_rx.sv
// Testbench for rx: table of directed frames plus hand-written sequences for
// idle line, glitch, mid-frame reset and back-to-back reception.
module tb_rx;

  localparam int B = 40;
  localparam int H = 20;

  logic       clk;
  logic       Reset;
  logic       Sin;
  logic       ReceiveAck;
  logic       Received;
  logic [7:0] Dout;
  logic       parityErr;
  logic       stopErr;
  logic [2:0] dbg_state;

  rx #(.BIT_CYCLES(B), .HALF_CYCLES(H)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .Sin        (Sin),
    .ReceiveAck (ReceiveAck),
    .Received   (Received),
    .Dout       (Dout),
    .parityErr  (parityErr),
    .stopErr    (stopErr),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- Received monitor ----------------
  int         rise_cnt  = 0;
  int         rise_cyc  = 0;
  int         hi_cycles = 0;
  logic       rcv_prev  = 1'b0;
  logic       sb_en     = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (Received === 1'b1 && rcv_prev !== 1'b1) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
      if (sb_en) got_q.push_back(Dout);
    end
    if (Received === 1'b1) hi_cycles <= hi_cycles + 1;
    rcv_prev <= Received;
  end

  // ---------------- check helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  int start_cyc = 0;

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; leaves Sin at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] data, input logic par_bit,
                            input logic stop_bit, input int period);
    Sin = 1'b0;
    start_cyc = cyc;
    wait_cycles(period);
    for (int i = 0; i < 8; i++) begin
      Sin = data[i];
      wait_cycles(period);
    end
    Sin = par_bit;
    wait_cycles(period);
    Sin = stop_bit;
    wait_cycles(period);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic       par_bit;
    logic       stop_bit;
    logic [7:0] exp_dout;
    logic       exp_perr;
    logic       exp_serr;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int idx);
    int rc0;
    int exp_rise;
    vec_t v;
    v = vecs[idx];
    ReceiveAck = 1'b0;
    rc0 = rise_cnt;
    send_frame(v.data, v.par_bit, v.stop_bit, B);
    exp_rise = start_cyc + H + 10 * B + 2;
    Sin = 1'b1;
    wait_cycles(B);
    chk_int($sformatf("v%0d_rise_count", idx), rise_cnt - rc0, 1);
    checks++;
    if (rise_cyc < exp_rise - 1 || rise_cyc > exp_rise + 1) begin
      errors++;
      $display("FAIL v%0d_rise_window actual=%0d required=%0d+-1", idx,
               rise_cyc - start_cyc, exp_rise - start_cyc);
    end
    chk8($sformatf("v%0d_received_held", idx), 8'(Received), 8'd1);
    chk8($sformatf("v%0d_dout", idx), Dout, v.exp_dout);
    chk8($sformatf("v%0d_parity_err", idx), 8'(parityErr), 8'(v.exp_perr));
    chk8($sformatf("v%0d_stop_err", idx), 8'(stopErr), 8'(v.exp_serr));
    ReceiveAck = 1'b1;
    wait_cycles(1);
    chk8($sformatf("v%0d_received_drop", idx), 8'(Received), 8'd0);
    ReceiveAck = 1'b0;
    wait_cycles(4);
  endtask

  // ---------------- test sequence ----------------
  int bad;
  int rc0;
  int hc0;

  initial begin
    vecs[0] = '{data: 8'hA5, par_bit: 1'b1, stop_bit: 1'b1, exp_dout: 8'hA5, exp_perr: 1'b0, exp_serr: 1'b0};
    vecs[1] = '{data: 8'h01, par_bit: 1'b1, stop_bit: 1'b1, exp_dout: 8'h01, exp_perr: 1'b1, exp_serr: 1'b0};
    vecs[2] = '{data: 8'h3C, par_bit: 1'b1, stop_bit: 1'b0, exp_dout: 8'h3C, exp_perr: 1'b0, exp_serr: 1'b1};
    vecs[3] = '{data: 8'h00, par_bit: 1'b1, stop_bit: 1'b1, exp_dout: 8'h00, exp_perr: 1'b0, exp_serr: 1'b0};
    vecs[4] = '{data: 8'hFF, par_bit: 1'b1, stop_bit: 1'b1, exp_dout: 8'hFF, exp_perr: 1'b0, exp_serr: 1'b0};
    vecs[5] = '{data: 8'h5A, par_bit: 1'b1, stop_bit: 1'b1, exp_dout: 8'h5A, exp_perr: 1'b0, exp_serr: 1'b0};

    // Reset
    Reset = 1'b1;
    Sin = 1'b1;
    ReceiveAck = 1'b0;
    wait_cycles(3);
    Reset = 1'b0;
    wait_cycles(1);
    chk8("rst_received", 8'(Received), 8'd0);
    chk8("rst_dout", Dout, 8'h00);
    chk8("rst_parity_err", 8'(parityErr), 8'd0);
    chk8("rst_stop_err", 8'(stopErr), 8'd0);
    chk8("rst_state", 8'(dbg_state), 8'd0);

    // Idle line: nothing moves for 20000 cycles
    bad = 0;
    for (int i = 0; i < 20000; i++) begin
      if (Received !== 1'b0 || Dout !== 8'h00 || parityErr !== 1'b0 || stopErr !== 1'b0)
        bad++;
      wait_cycles(1);
    end
    chk_int("idle_bad_cycles", bad, 0);

    // Good frame, bad parity, bad stop, stop-error clear
    for (int i = 0; i < 4; i++) run_vec(i);

    // Glitch shorter than half a bit: rejected at the mid-point check
    rc0 = rise_cnt;
    Sin = 1'b0;
    wait_cycles(H / 2);
    Sin = 1'b1;
    wait_cycles(12 * B);
    chk_int("glitch_no_rise", rise_cnt - rc0, 0);
    chk8("glitch_state_idle", 8'(dbg_state), 8'd0);

    for (int i = 4; i < 5; i++) run_vec(i);

    // Reset in the middle of data bit 4 of 8'h5A
    rc0 = rise_cnt;
    Sin = 1'b0;
    wait_cycles(B);
    for (int i = 0; i < 4; i++) begin
      Sin = vecs[5].data[i];
      wait_cycles(B);
    end
    Sin = vecs[5].data[4];
    wait_cycles(B / 2);
    Reset = 1'b1;
    wait_cycles(1);
    chk8("midrst_received", 8'(Received), 8'd0);
    chk8("midrst_dout", Dout, 8'h00);
    chk8("midrst_parity_err", 8'(parityErr), 8'd0);
    chk8("midrst_stop_err", 8'(stopErr), 8'd0);
    chk8("midrst_state", 8'(dbg_state), 8'd0);
    Reset = 1'b0;
    wait_cycles(B / 2 - 1);
    for (int i = 5; i < 8; i++) begin
      Sin = vecs[5].data[i];
      wait_cycles(B);
    end
    Sin = vecs[5].par_bit;
    wait_cycles(B);
    Sin = 1'b1;
    wait_cycles(B);
    chk_int("midrst_no_rise_in_frame", rise_cnt - rc0, 0);
    // A later falling edge inside the aborted frame can start a fresh
    // capture; acknowledge through it so the receiver is back in IDLE.
    ReceiveAck = 1'b1;
    wait_cycles(12 * B);
    ReceiveAck = 1'b0;
    wait_cycles(4);

    for (int i = 5; i < 6; i++) run_vec(i);

    // Back-to-back frames, ReceiveAck held high, periods 40/41/39 cycles
    got_q.delete();
    exp_q.delete();
    exp_q.push_back(8'h96);
    exp_q.push_back(8'h69);
    exp_q.push_back(8'hC3);
    sb_en = 1'b1;
    rc0 = rise_cnt;
    hc0 = hi_cycles;
    ReceiveAck = 1'b1;
    send_frame(8'h96, 1'b1, 1'b1, B);
    send_frame(8'h69, 1'b1, 1'b1, B + 1);
    send_frame(8'hC3, 1'b1, 1'b1, B - 1);
    Sin = 1'b1;
    wait_cycles(2 * B);
    sb_en = 1'b0;
    ReceiveAck = 1'b0;
    chk_int("b2b_rise_count", rise_cnt - rc0, 3);
    chk_int("b2b_high_cycles", hi_cycles - hc0, 3);
    chk_int("b2b_byte_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk8("b2b_byte", got_q.pop_front(), exp_q.pop_front());
    chk8("b2b_parity_err", 8'(parityErr), 8'd0);
    chk8("b2b_stop_err", 8'(stopErr), 8'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx.md
# rx

UART receiver paired with the `tx` transmitter on the same serial link. It deserializes frames of 1 start bit (0), 8 data bits LSB first, 1 odd-parity bit and 1 stop bit (1) from `Sin`. It presents the byte with parity and framing status and holds it under a `Received`/`ReceiveAck` handshake, mirroring the transmitter's `Sent`/`Send` handshake. It sits between the board RX pin and the user logic that consumes bytes.

## Interface
- `BIT_CYCLES`, default 5209: clock cycles per bit, matching the transmitter bit period (timer 0..5208).
- `HALF_CYCLES`, default 2604: cycles from start-bit detection to the start-bit mid-point check.
- `clk`  input  1  system clock; all logic on rising edge.
- `Reset`  input  1  synchronous, active-high reset; clock `clk`.
- `Sin`  input  1  asynchronous serial line; idles high.
- `ReceiveAck`  input  1  consumer acknowledge; returns FSM from ACK to IDLE.
- `Received`  output  1  high while a completed byte is held in ACK state.
- `Dout`  output  8  last received data byte.
- `parityErr`  output  1  high if the last frame failed odd parity (data + parity ones count even).
- `stopErr`  output  1  high if the last frame's stop bit sampled 0.

## Operation
- Input sync: two flip-flops on `Sin`, both reset to 1. The synchronized signal is `sinS`. All FSM decisions use `sinS` only.
- Bit timer: 13-bit counter. It clears in IDLE and on every state transition, and otherwise increments. `halfDone` = (timer == `HALF_CYCLES`-1). `timerDone` = (timer == `BIT_CYCLES`-1). Timer wraps to 0 when `timerDone` is true.
- Bit counter: 3 bits. It clears on entry to BITS and increments on each data sample. `bitDone` = (count == 7).
- Shift register: 8 bits. On each data sample it shifts right with `sinS` inserted at bit 7, so 8 samples leave the first (LSB) bit in bit 0.
- FSM states and transitions; `Reset` forces IDLE from any state:
  - IDLE: timer held clear. `sinS`==0 -> START.
  - START: on `halfDone`, `sinS`==0 -> BITS; `sinS`==1 -> IDLE (false start, no outputs change).
  - BITS: on `timerDone`, sample into the shift register. If `bitDone`, go to PAR; else increment the bit counter and stay.
  - PAR: on `timerDone`, capture the parity sample -> STOP.
  - STOP: on `timerDone`, load `Dout` from the shift register. Set `parityErr` = ~(^{shift, parity sample}) and `stopErr` = ~`sinS` -> ACK.
  - ACK: `Received`=1. If `ReceiveAck`==1 -> IDLE, else stay.
- `Dout`, `parityErr` and `stopErr` are registered. They change only on the STOP->ACK transition or on reset, and hold through IDLE until the next completed frame.
- A frame whose start bit falls while in ACK is ignored; only IDLE detects start bits.
- `stopErr` or `parityErr` frames still complete to ACK, and `Dout` is still updated.

## Timing
- Reset values: `Received`=0, `Dout`=8'h00, `parityErr`=0, `stopErr`=0, state IDLE, sync flops 1, timer 0, bit counter 0.
- Reset asserted mid-frame: next cycle is IDLE and all outputs are at reset values; the partial frame is discarded.
- `Sin` falling edge at cycle t: `sinS` is low at t+2 and START is entered at t+3.
- Start mid-point check at t+3+`HALF_CYCLES`-1. Each subsequent sample is `BIT_CYCLES` later, so samples land at bit centers ±1 cycle.
- `Received` rises at t + `HALF_CYCLES` + 10·`BIT_CYCLES` + 2, tolerance ±1 cycle. The bench checks this window.
- `ReceiveAck` high in ACK: `Received` falls the next cycle. If `ReceiveAck` is held high permanently, `Received` is a 1-cycle pulse per frame.
- Back-to-back frames with zero idle between stop and next start are received correctly when `ReceiveAck` is already high.
- Transmitter period mismatch up to ±2% must still decode correctly.

## Test plan
- Reset, then idle line: `Received`=0, `Dout`=00, `parityErr`=0 and `stopErr`=0 for 20000 cycles.
- `tx`-driven frame 8'hA5 (parity bit 1), `ReceiveAck` low: `Received` rises within the Timing window with `Dout`=A5 and both error flags 0. It stays high until `ReceiveAck`=1 and falls one cycle later.
- Hand-built frame 8'h01 with parity bit 1 (wrong): `Dout`=01, `parityErr`=1, `stopErr`=0.
- Frame 8'h3C with stop bit forced 0: `Dout`=3C, `stopErr`=1. A following valid frame 8'h00 clears `stopErr`.
- Glitch: `Sin` low for 1000 cycles, then high: FSM returns to IDLE and `Received` never asserts. A subsequent frame 8'hFF decodes correctly.
- `Reset` pulsed during data bit 4 of frame 8'h5A: outputs return to reset values. The remainder of that frame produces no `Received`, and the next frame 8'h5A decodes correctly.
